// File: rtl/lat_data_mem.sv
// Handshaked data memory with configurable latency, byte-enable writes and
// error responses for misaligned or out-of-range addresses.
module lat_data_mem #(
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 64,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic [1:0]          dbg_state_o
);

  // Handshake: a request is taken on a rising edge where req_valid && req_ready;
  // the response is a single-cycle rsp_valid strobe with no backpressure.

  localparam int NB  = DATA_W / 8;
  localparam int OFF = $clog2(NB);
  localparam int IW  = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] LO_MASK  = ADDR_W'((64'd1 << OFF) - 64'd1);
  localparam logic [3:0]        CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [NB-1:0]     be_q;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              accept;
  logic              enter_resp;
  logic              acc_we;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic [NB-1:0]     acc_be;
  logic [IW-1:0]     acc_idx;
  logic              acc_err;
  logic              do_write;

  assign req_ready   = (state_q != S_WAIT);
  assign accept      = req_valid && req_ready;
  assign rsp_valid   = (state_q == S_RESP);
  assign rsp_rdata   = rdata_q;
  assign rsp_err     = err_q;
  assign dbg_state_o = state_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    case (state_q)
      S_IDLE, S_RESP: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_d    = S_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d    = S_RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // With single-cycle latency the access happens on the accept edge itself,
  // so the live request inputs are used instead of the captured copies.
  always_comb begin
    acc_we    = (LATENCY == 1) ? req_we    : we_q;
    acc_addr  = (LATENCY == 1) ? req_addr  : addr_q;
    acc_wdata = (LATENCY == 1) ? req_wdata : wdata_q;
    acc_be    = (LATENCY == 1) ? req_be    : be_q;
    acc_idx   = IW'(acc_addr >> OFF);
    acc_err   = ((acc_addr & LO_MASK) != '0) || ((acc_addr >> (OFF + IW)) != '0);
    do_write  = enter_resp && acc_we && !acc_err && !rst;
    rdata_d   = '0;
    err_d     = 1'b0;
    if (enter_resp) begin
      err_d = acc_err;
      if (!acc_we && !acc_err) rdata_d = mem[acc_idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        be_q    <= req_be;
      end
    end
  end

  // Storage is deliberately outside the reset domain so preloaded contents survive.
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int i = 0; i < NB; i++) begin
        if (acc_be[i]) mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: doc/lat_data_mem.md
Name: lat_data_mem

Overview:
- Parametrised, handshaked successor to the fixed single-cycle data memory used in CPU benches and top-level simulation.
- Has configurable width, depth and access latency, byte-enable writes, and error reporting for misaligned or out-of-range accesses.
- Sits between the core's memory stage (or a bench driver) and a behavioural storage array. The array is preloadable via $readmemb on hierarchical name `mem`.

Parameters:
- DATA_W, 64, data word width in bits; multiple of 8, power of two.
- ADDR_W, 64, request address width in bits (byte address).
- DEPTH, 256, number of words; power of two.
- LATENCY, 2, cycles from request acceptance to response; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request this cycle.
- req_we  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_W  byte address.
- req_wdata  input  DATA_W  write data.
- req_be  input  DATA_W/8  byte enables; bit i controls byte i.
- rsp_valid  output  1  one-cycle response strobe.
- rsp_rdata  output  DATA_W  read data; 0 for writes and errors.
- rsp_err  output  1  response is an error; qualified by rsp_valid.

Behaviour:
- Reset (async, while rst=1):
  - req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, FSM=IDLE, latency counter=0.
  - Storage array is NOT cleared.
- Acceptance:
  - A request is accepted on a rising edge where req_valid && req_ready.
  - Attributes (we, addr, wdata, be) are captured into registers at that edge.
  - Request inputs are ignored at all other edges.
- FSM states:
  - IDLE: req_ready=1. On accept: if LATENCY==1 go to RESP, else go to WAIT with cnt=LATENCY-2.
  - WAIT: req_ready=0. If cnt==0 go to RESP, else cnt--.
  - RESP: rsp_valid=1 for exactly this cycle; req_ready=1. On accept go to WAIT/RESP as from IDLE (back-to-back), else go to IDLE.
- Timing: a request accepted at edge N produces rsp_valid high in the cycle following edge N+LATENCY-1. For LATENCY=1, rsp_valid is high in the cycle right after acceptance. Sustained throughput is one request per LATENCY cycles.
- Memory access:
  - Performed on the edge that enters RESP, using captured attributes.
  - Read: rsp_rdata = mem[idx] as of that edge.
  - Write: for each i with be[i]=1, mem[idx] byte i = wdata byte i; bytes with be[i]=0 are unchanged. rsp_rdata=0.
  - be=0 write: legal no-op, rsp_err=0.
- Address decode:
  - OFF = log2(DATA_W/8), IW = log2(DEPTH).
  - idx = addr[OFF+IW-1:OFF].
- Error handling:
  - rsp_err=1 if addr[OFF-1:0]!=0 (misaligned), or any addr bit at or above OFF+IW is set (out of range).
  - On error: no memory write, rsp_rdata=0; the response still arrives at normal latency.
- Response: there is no response backpressure. rsp_valid is a strobe; the consumer must sample it. rsp_rdata and rsp_err return to 0 the cycle after RESP unless another RESP follows.
- Reset mid-operation: the pending request is discarded with no write and no response. After reset release the block is in IDLE.
- Simultaneous events:
  - A request accepted in a RESP cycle does not affect the current response.
  - A read of the address written by the immediately preceding request returns the new data.

Test Plan:
- Reset with LATENCY=2, DATA_W=64, mem preloaded mem[3]=64'h1122334455667788. Read addr=0x18 → rsp_valid exactly 2 cycles after accept, rsp_rdata=64'h1122334455667788, rsp_err=0; req_ready low for 1 cycle.
- Write addr=0x18, wdata=64'hAAAAAAAAAAAAAAAA, be=8'h0F, then back-to-back read of 0x18 accepted in the RESP cycle → rsp_rdata=64'h11223344AAAAAAAA.
- Read addr=0x1C (misaligned) and addr=0x800 (out of range, DEPTH=256) → rsp_err=1, rsp_rdata=0 at normal latency. A subsequent write to 0x800 leaves all mem entries unchanged.
- LATENCY=1: four consecutive reads of 0x0, 0x8, 0x10, 0x18 with req_valid held high → four consecutive rsp_valid cycles; req_ready stays 1 throughout.
- LATENCY=5: accept a write to 0x20, assert rst 2 cycles later for 1 cycle → no rsp_valid, mem[4] unchanged, req_ready=1 immediately during rst. A post-reset read of 0x20 returns the old data after 5 cycles.
- Hold req_valid=1 while req_ready=0 with changing addr → only the addr present at the accept edge is serviced; exactly one response per accept.
